// File: rtl/alu_seq_pkg.sv
// Shared opcodes, response flag bit positions and FSM encoding for the
// accumulator-based ALU command sequencer.
package alu_seq_pkg;

  localparam int BUS_WIDTH = 8;
  localparam int OP_W      = 4;
  localparam int FLAG_W    = 5;

  localparam logic [OP_W-1:0] OP_LOAD      = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD       = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD_CARRY = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB       = 4'd3;
  localparam logic [OP_W-1:0] OP_INC       = 4'd4;
  localparam logic [OP_W-1:0] OP_DEC       = 4'd5;
  localparam logic [OP_W-1:0] OP_AND       = 4'd6;
  localparam logic [OP_W-1:0] OP_NOT       = 4'd7;
  localparam logic [OP_W-1:0] OP_ROL       = 4'd8;
  localparam logic [OP_W-1:0] OP_ROR       = 4'd9;

  localparam int FLAG_CARRY   = 0;
  localparam int FLAG_BORROW  = 1;
  localparam int FLAG_ZERO    = 2;
  localparam int FLAG_PARITY  = 3;
  localparam int FLAG_INVALID = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_rsp_reg.sv
// One-entry response holding register: load captures y/flags and raises valid,
// a valid&ready handshake drops valid, clr empties it and zeroes the data.
module alu_seq_rsp_reg
  import alu_seq_pkg::*;
#(
  parameter int W = BUS_WIDTH
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [W-1:0]      load_y,
  input  logic [FLAG_W-1:0] load_flags,
  input  logic              ready,
  output logic              valid,
  output logic [W-1:0]      y,
  output logic [FLAG_W-1:0] flags
);

  logic              valid_q, valid_d;
  logic [W-1:0]      y_q, y_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  always_comb begin
    valid_d = valid_q;
    y_d     = y_q;
    flags_d = flags_q;
    if (load) begin
      valid_d = 1'b1;
      y_d     = load_y;
      flags_d = load_flags;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

  assign valid = valid_q;
  assign y     = y_q;
  assign flags = flags_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Accumulator command sequencer driving an external combinational ALU.
// Optional sticky invalid-op flag: define ALU_SEQ_STICKY_ERR_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; the initiator holds valid and payload stable until that edge, and the
// receiver may drive ready independently of valid.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int BW = BUS_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_opcode,
  input  logic [BW-1:0]     cmd_operand,
  output logic [BW-1:0]     alu_a,
  output logic [BW-1:0]     alu_b,
  output logic              alu_carry_in,
  output logic [3:0]        alu_opcode,
  input  logic [BW-1:0]     alu_y,
  input  logic              alu_carry_out,
  input  logic              alu_borrow,
  input  logic              alu_zero,
  input  logic              alu_parity,
  input  logic              alu_invalid_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BW-1:0]     rsp_y,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              err_sticky,
  output logic [1:0]        dbg_state
);

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [BW-1:0]   operand_q, operand_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [BW-1:0]   alu_a_q, alu_a_d;
  logic [BW-1:0]   alu_b_q, alu_b_d;
  logic            alu_cin_q, alu_cin_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            cmd_ready_q, cmd_ready_d;

  logic              rsp_load;
  logic [BW-1:0]     rsp_load_y;
  logic [FLAG_W-1:0] rsp_load_flags;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    operand_d      = operand_q;
    acc_d          = acc_q;
    carry_d        = carry_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_cin_d      = alu_cin_q;
    alu_op_d       = 4'd0;
    rsp_load       = 1'b0;
    rsp_load_y     = '0;
    rsp_load_flags = '0;
    unique case (state_q)
      ST_IDLE: begin
        // LOAD also passes through ISSUE so both command kinds share one latency;
        // its opcode is 0, so the ALU bus shows no operation for it.
        if (cmd_valid && cmd_ready_q) begin
          op_d      = cmd_opcode;
          operand_d = cmd_operand;
          alu_a_d   = acc_q;
          alu_b_d   = cmd_operand;
          alu_cin_d = carry_q;
          alu_op_d  = cmd_opcode;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rsp_load = 1'b1;
        state_d  = ST_RESP;
        if (op_q == OP_LOAD) begin
          acc_d                       = operand_q;
          carry_d                     = 1'b0;
          rsp_load_y                  = operand_q;
          rsp_load_flags[FLAG_PARITY] = ^operand_q;
          rsp_load_flags[FLAG_ZERO]   = (operand_q == '0);
        end else begin
          rsp_load_flags[FLAG_CARRY]   = alu_carry_out;
          rsp_load_flags[FLAG_BORROW]  = alu_borrow;
          rsp_load_flags[FLAG_ZERO]    = alu_zero;
          rsp_load_flags[FLAG_PARITY]  = alu_parity;
          rsp_load_flags[FLAG_INVALID] = alu_invalid_op;
          if (!alu_invalid_op) begin
            acc_d      = alu_y;
            carry_d    = alu_carry_out;
            rsp_load_y = alu_y;
          end
        end
      end
      ST_RESP: begin
        if (rsp_valid && rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      operand_q   <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      alu_op_q    <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      operand_q   <= operand_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      alu_op_q    <= alu_op_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  alu_seq_rsp_reg #(.W(BW)) u_rsp_reg (
    .clk        (clk),
    .clr        (rst),
    .load       (rsp_load),
    .load_y     (rsp_load_y),
    .load_flags (rsp_load_flags),
    .ready      (rsp_ready),
    .valid      (rsp_valid),
    .y          (rsp_y),
    .flags      (rsp_flags)
  );

`ifdef ALU_SEQ_STICKY_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == ST_ISSUE && op_q != OP_LOAD && alu_invalid_op) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_sticky = err_q;
`else
  assign err_sticky = 1'b0;
`endif

  assign cmd_ready    = cmd_ready_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_carry_in = alu_cin_q;
  assign alu_opcode   = alu_op_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ALU on the alu_* bus, an accumulator
// reference model, directed scenarios and a randomized command stream.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_operand;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_carry_in;
  logic [3:0] alu_opcode;
  logic       alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_y;
  logic [4:0] rsp_flags;
  logic       err_sticky;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  logic [12:0] exp_q[$];
  logic [7:0]  mdl_acc;
  logic        mdl_carry;
  logic        mdl_err;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in), .alu_opcode(alu_opcode),
    .alu_y(alu_y), .alu_carry_out(alu_carry_out), .alu_borrow(alu_borrow),
    .alu_zero(alu_zero), .alu_parity(alu_parity), .alu_invalid_op(alu_invalid_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags),
    .err_sticky(err_sticky), .dbg_state(dbg_state)
  );

  // Returns {invalid, parity, zero, borrow, carry, y[7:0]}.
  function automatic logic [12:0] alu_eval(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
    int         r;
    logic [7:0] y;
    logic       c, bo, inv;
    c = 1'b0; bo = 1'b0; inv = 1'b0; y = 8'h00;
    case (op)
      4'd0: y = b;
      4'd1: begin r = int'(a) + int'(b);              y = r[7:0]; c = r[8]; end
      4'd2: begin r = int'(a) + int'(b) + int'(cin);  y = r[7:0]; c = r[8]; end
      4'd3: begin r = int'(a) - int'(b);              y = r[7:0]; bo = (a < b); end
      4'd4: begin r = int'(a) + 1;                    y = r[7:0]; c = r[8]; end
      4'd5: begin r = int'(a) - 1;                    y = r[7:0]; bo = (a == 8'h00); end
      4'd6: y = a & b;
      4'd7: y = ~a;
      4'd8: y = {a[6:0], a[7]};
      4'd9: y = {a[0], a[7:1]};
      default: inv = 1'b1;
    endcase
    return {inv, (inv ? 1'b0 : ^y), (y == 8'h00), bo, c, y};
  endfunction

  logic [12:0] alu_res;
  always_comb alu_res = alu_eval(alu_opcode, alu_a, alu_b, alu_carry_in);
  assign alu_y          = alu_res[7:0];
  assign alu_carry_out  = alu_res[8];
  assign alu_borrow     = alu_res[9];
  assign alu_zero       = alu_res[10];
  assign alu_parity     = alu_res[11];
  assign alu_invalid_op = alu_res[12];

  task automatic model_reset();
    mdl_acc = 8'h00; mdl_carry = 1'b0; mdl_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [3:0] op, input logic [7:0] b, output logic [12:0] e);
    logic [12:0] r;
    if (op == 4'd0) begin
      e = {1'b0, ^b, (b == 8'h00), 2'b00, b};
      mdl_acc = b; mdl_carry = 1'b0;
    end else begin
      r = alu_eval(op, mdl_acc, b, mdl_carry);
      e = r;
      if (r[12]) mdl_err = 1'b1;
      else begin mdl_acc = r[7:0]; mdl_carry = r[8]; end
    end
  endtask

  task automatic wait_cmd_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [7:0] b, input int rdy_delay,
                        output logic [7:0] y, output logic [4:0] f);
    logic [12:0] e;
    model_step(op, b, e);
    exp_q.push_back(e);
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_opcode = op; cmd_operand = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (alu_opcode !== op || alu_b !== b || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL issue_bus: opcode=%0d b=%h ready=%b rsp_valid=%b required %0d %h 0 0",
               alu_opcode, alu_b, cmd_ready, rsp_valid, op, b);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rsp_latency: rsp_valid=%b required 1", rsp_valid);
    end
    repeat (rdy_delay) begin @(posedge clk); #1; end
    y = rsp_y; f = rsp_flags;
    e = exp_q.pop_front();
    checks++;
    if ({f, y} !== e) begin
      errors++;
      $display("FAIL rsp_data op=%0d b=%h: y=%h flags=%b required y=%h flags=%b",
               op, b, y, f, e[7:0], e[12:8]);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rsp_drop: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_operand = 8'h00; rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_y !== 8'h00 || rsp_flags !== 5'h00 ||
        alu_a !== 8'h00 || alu_b !== 8'h00 || alu_carry_in !== 1'b0 || alu_opcode !== 4'h0 ||
        err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b v=%b y=%h f=%b a=%h b=%h ci=%b op=%h err=%b required all 0",
               cmd_ready, rsp_valid, rsp_y, rsp_flags, alu_a, alu_b, alu_carry_in, alu_opcode, err_sticky);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_carry_chain();
    logic [7:0] y; logic [4:0] f;
    do_cmd(4'd0, 8'hFF, 0, y, f);
    do_cmd(4'd2, 8'h01, 1, y, f);
    checks++;
    if (y !== 8'h00 || f !== 5'b00101) begin
      errors++; $display("FAIL adc_wrap: y=%h flags=%b required y=00 flags=00101", y, f);
    end
    do_cmd(4'd2, 8'h00, 0, y, f);
    checks++;
    if (y !== 8'h01 || f[0] !== 1'b0) begin
      errors++; $display("FAIL adc_chain: y=%h carry=%b required y=01 carry=0", y, f[0]);
    end
  endtask

  task automatic test_inc_dec();
    logic [7:0] y; logic [4:0] f;
    do_cmd(4'd0, 8'h00, 0, y, f);
    do_cmd(4'd5, 8'h00, 0, y, f);
    checks++;
    if (y !== 8'hFF || f !== 5'b00010) begin
      errors++; $display("FAIL dec_underflow: y=%h flags=%b required y=ff flags=00010", y, f);
    end
    do_cmd(4'd4, 8'h00, 2, y, f);
    checks++;
    if (y !== 8'h00 || f !== 5'b00101) begin
      errors++; $display("FAIL inc_overflow: y=%h flags=%b required y=00 flags=00101", y, f);
    end
  endtask

  task automatic test_rotate();
    logic [7:0] y; logic [4:0] f;
    do_cmd(4'd0, 8'h81, 0, y, f);
    do_cmd(4'd8, 8'h00, 0, y, f);
    checks++;
    if (y !== 8'h03) begin
      errors++; $display("FAIL rol: y=%h required 03", y);
    end
    do_cmd(4'd9, 8'h00, 0, y, f);
    checks++;
    if (y !== 8'h81 || f[3] !== 1'b0) begin
      errors++; $display("FAIL ror: y=%h parity=%b required y=81 parity=0", y, f[3]);
    end
  endtask

  task automatic test_invalid_op();
    logic [7:0] y; logic [4:0] f; logic exp_err;
`ifdef ALU_SEQ_STICKY_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_cmd(4'd0, 8'h5A, 0, y, f);
    do_cmd(4'd12, 8'h33, 0, y, f);
    checks++;
    if (y !== 8'h00 || f[4] !== 1'b1 || f[2] !== 1'b1 || err_sticky !== exp_err) begin
      errors++;
      $display("FAIL invalid_op: y=%h inv=%b zero=%b err=%b required y=00 inv=1 zero=1 err=%b",
               y, f[4], f[2], err_sticky, exp_err);
    end
    do_cmd(4'd7, 8'h00, 0, y, f);
    checks++;
    if (y !== 8'hA5 || err_sticky !== exp_err) begin
      errors++; $display("FAIL acc_kept: y=%h err=%b required y=a5 err=%b", y, err_sticky, exp_err);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] y; logic [4:0] f; logic [12:0] e;
    do_cmd(4'd0, 8'h33, 0, y, f);
    model_step(4'd1, 8'h10, e);
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_opcode = 4'd1; cmd_operand = 8'h10; rsp_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready_issue: cmd_ready=%b required 0", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_y !== 8'h43 || {rsp_flags, rsp_y} !== e) begin
      errors++; $display("FAIL bp_first: v=%b y=%h f=%b required v=1 y=43 f=%b",
                         rsp_valid, rsp_y, rsp_flags, e[12:8]);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_flags, rsp_y} !== e || cmd_ready !== 1'b0 || alu_opcode !== 4'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%b y=%h f=%b rdy=%b op=%0d required v=1 y=%h f=%b rdy=0 op=0",
                 i, rsp_valid, rsp_y, rsp_flags, cmd_ready, alu_opcode, e[7:0], e[12:8]);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: v=%b rdy=%b required v=0 rdy=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] y; logic [4:0] f;
    do_cmd(4'd0, 8'h20, 0, y, f);
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_opcode = 4'd1; cmd_operand = 8'h05;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (rsp_valid !== 1'b0 || alu_opcode !== 4'd0 || err_sticky !== 1'b0) begin
      errors++; $display("FAIL mid_reset: v=%b op=%0d err=%b required 0 0 0",
                         rsp_valid, alu_opcode, err_sticky);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL mid_reset_drop[%0d]: rsp_valid=%b required 0", i, rsp_valid);
      end
    end
    do_cmd(4'd1, 8'h07, 0, y, f);
    checks++;
    if (y !== 8'h07) begin
      errors++; $display("FAIL acc_after_reset: y=%h required 07", y);
    end
  endtask

  task automatic test_random();
    logic [7:0] y; logic [4:0] f;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      do_cmd(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), $urandom_range(0, 3), y, f);
    end
    checks++;
`ifdef ALU_SEQ_STICKY_ERR_EN
    if (err_sticky !== mdl_err) begin
      errors++; $display("FAIL sticky_random: err=%b required %b", err_sticky, mdl_err);
    end
`else
    if (err_sticky !== 1'b0) begin
      errors++; $display("FAIL sticky_random: err=%b required 0", err_sticky);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_carry_chain();
    test_inc_dec();
    test_rotate();
    test_invalid_op();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Accumulator-based command sequencer that acts as the initiator side of the 8-bit ALU interface. It accepts a valid/ready stream of {opcode, operand} commands, drives the ALU input bus (a from the accumulator, b from the operand, carry_in from a stored carry bit), and captures the ALU result and flags. It then returns them on a valid/ready response stream. It sits between a command source (CPU stub or bench) and the combinational ALU, so multi-word arithmetic can be chained through the carry register.

## Interface
- BUS_WIDTH, 8, datapath width of the accumulator, operand, ALU a/b/y and rsp_y.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_opcode  in  4  0 = LOAD (local, no ALU issue); 1..9 = ALU ADD, ADD_CARRY, SUB, INC, DEC, AND, NOT, ROL, ROR; 10..15 are passed to the ALU and must return invalid_op.
- cmd_operand  in  BUS_WIDTH  b operand, or LOAD value.
- alu_a, alu_b  out  BUS_WIDTH  ALU operands (registered).
- alu_carry_in  out  1  ALU carry in (registered).
- alu_opcode  out  4  ALU opcode, 0 outside ISSUE.
- alu_y  in  BUS_WIDTH  ALU result.
- alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op  in  1 each  ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_y  out  BUS_WIDTH  result.
- rsp_flags  out  5  {invalid_op, parity, zero, borrow, carry_out}, bit 4 down to 0.
- err_sticky  out  1  sticky invalid-op indicator (see Configuration).

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch the opcode and operand. ALU opcodes go to ISSUE. LOAD goes to RESP directly after one internal cycle, giving the same latency as an ALU op.
- ISSUE: alu_a=acc, alu_b=operand, alu_carry_in=carry_reg and alu_opcode=latched opcode are all stable for the whole cycle. At the end of the cycle, sample alu_y and the flags into the response register, then go to RESP.
- RESP: rsp_valid=1. rsp_y and rsp_flags are held stable until rsp_ready=1. On handshake, go to IDLE.
- Accumulator and carry update happen at the ISSUE sample edge:
  - If alu_invalid_op=0: acc<=alu_y, carry_reg<=alu_carry_out.
  - If alu_invalid_op=1: acc and carry_reg are unchanged. The response still reports y=0 with invalid_op=1.
- LOAD: acc<=operand, carry_reg<=0. Response is y=operand, flags={0, ^operand, operand==0, 0, 0}.
- alu_borrow is reported only and never stored.
- Width rule: all arithmetic is modulo 2^BUS_WIDTH. The carry/borrow bit comes from the ALU only.

## Timing
- Command accepted at edge N: ALU driven during cycle N+1, rsp_valid high from N+2.
- Throughput: at most one command per 3 cycles. There is no overlap of RESP and IDLE.
- cmd_ready is 0 in ISSUE and RESP, regardless of cmd_valid.
- Backpressure: while rsp_valid=1 and rsp_ready=0, every output stays frozen.
- Reset values: cmd_ready=0 during the reset cycle and 1 on the cycle after. rsp_valid=0, rsp_y=0, rsp_flags=0, alu_a=0, alu_b=0, alu_carry_in=0, alu_opcode=0, err_sticky=0. acc=0, carry_reg=0, state=IDLE.
- Reset mid-operation: rst in ISSUE or RESP aborts the command. Any pending response is dropped and never presented.
- rst has priority over any simultaneous handshake.

## Configuration
- ALU_SEQ_STICKY_ERR_EN defined: err_sticky is set at the ISSUE sample edge when alu_invalid_op=1. It is cleared only by rst, and subsequent commands still execute.
- Undefined: err_sticky is tied to 0 and the register is not built. Per-response invalid_op still works.

## Structure
- alu_seq_pkg holds:
  - Opcode localparams (LOAD=0, ADD=1 … ROR=9).
  - rsp_flags bit indices (CARRY=0, BORROW=1, ZERO=2, PARITY=3, INVALID=4).
  - State encoding.
- The block does not instantiate the ALU. The bench connects the ALU between the alu_* ports.
- Sub-module alu_seq_rsp_reg: a one-entry response holding register with valid/ready, load and clear inputs.

## Test plan
- LOAD 0xFF; ADD_CARRY 0x01 -> y=0x00, carry_out=1, zero=1, parity=0. Then ADD_CARRY 0x00 -> y=0x01, carry_out=0, which checks that the chained carry was used.
- LOAD 0x00; DEC -> y=0xFF, borrow=1, parity=0, zero=0. Then INC -> y=0x00, carry_out=1, zero=1.
- LOAD 0x81; ROL -> y=0x03. Then ROR -> y=0x81, parity=0.
- LOAD 0x5A; opcode 12 -> invalid_op=1, y=0, zero=1, err_sticky=1 (macro defined) or 0 (undefined). Then NOT -> y=0xA5, which checks the accumulator was kept.
- Hold rsp_ready=0 for 5 cycles after rsp_valid rises, with cmd_valid held high -> rsp_y/rsp_flags stable, cmd_ready=0, no second command accepted. The first cmd_ready=1 comes one cycle after the handshake.
- Assert rst for one cycle during ISSUE -> next cycle rsp_valid=0, alu_opcode=0. A following ADD 0x07 returns y=0x07, confirming acc=0.
